fetch_sequencer: RTL and testbench

//  Multi-cycle fetch/PC sequencer for the MIPS core. Owns the program counter, requests instructions

---
 rtl/fetch_seq_pkg.sv | 16 +
 rtl/next_pc_calc.sv | 34 +++
 rtl/fetch_sequencer.sv | 145 ++++++++++++++
 tb/tb_fetch_sequencer.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding, reset PC and PC increment.
package fetch_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_ISSUE   = 3'd2,
    S_RESOLVE = 3'd3,
    S_ERROR   = 3'd4
  } fetch_state_e;

  localparam logic [31:0] DEFAULT_RESET_PC       = 32'h0000_0000;
  localparam logic [31:0] PC_INCR                = 32'd4;
  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC select for a resolved instruction: jump target, taken branch, or pc+4.
module next_pc_calc
  import fetch_seq_pkg::*;
(
  input  logic [31:0] instr_pc_i,
  input  logic [31:0] instr_i,
  input  logic        branch_i,
  input  logic        zero_i,
  input  logic        jump_i,
  output logic [31:0] next_pc_o
);

  logic [31:0] pcplus4;
  logic [31:0] branch_off;
  logic [31:0] jump_target;
  logic        unused_opcode;

  assign pcplus4     = instr_pc_i + PC_INCR;
  assign branch_off  = {{14{instr_i[15]}}, instr_i[15:0], 2'b00};
  assign jump_target = {pcplus4[31:28], instr_i[25:0], 2'b00};
  // The opcode field plays no part in target selection; the datapath decodes it.
  assign unused_opcode = ^instr_i[31:26];

  always_comb begin
    // NOTE: give every combinational output a default first so no path can infer a latch.
    next_pc_o = pcplus4;
    if (jump_i) begin
      next_pc_o = jump_target;
    end else if (branch_i && zero_i) begin
      next_pc_o = pcplus4 + branch_off;
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/PC sequencer: owns the PC, fetches from imem over req/ack and issues to decode over valid/ready.
// Define FETCH_TIMEOUT_EN to add an imem ack timeout that parks the FSM in a sticky ERROR state.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC       = DEFAULT_RESET_PC,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  input  logic        resolve_valid,
  input  logic        branch_control,
  input  logic        alu_zero_control,
  input  logic        jump_control,
  output logic [31:0] pc,
  output logic [31:0] fetch_count,
  output logic        fetch_error
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  instr_pc_q, instr_pc_d;
  logic [31:0]  count_q, count_d;
  logic [31:0]  next_pc;
  logic         timeout_hit;

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;

  // Counts completed no-ack FETCH cycles; held at zero outside FETCH so each fetch starts fresh.
  always_comb begin
    to_cnt_d = to_cnt_q;
    if (state_q != S_FETCH) begin
      to_cnt_d = '0;
    end else if (!imem_ack) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (state_q == S_FETCH) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) to_cnt_q <= '0;
    else       to_cnt_q <= to_cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  next_pc_calc u_next_pc (
    .instr_pc_i (instr_pc_q),
    .instr_i    (instr_q),
    .branch_i   (branch_control),
    .zero_i     (alu_zero_control),
    .jump_i     (jump_control),
    .next_pc_o  (next_pc)
  );

  always_ff @(posedge clock or posedge reset) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values of the others.
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    state_d = S_FETCH;
      // An ack on the last allowed cycle takes priority over the timeout.
      S_FETCH: begin
        if (imem_ack)         state_d = S_ISSUE;
        else if (timeout_hit) state_d = S_ERROR;
      end
      S_ISSUE:   if (instr_ready)   state_d = S_RESOLVE;
      S_RESOLVE: if (resolve_valid) state_d = S_FETCH;
      S_ERROR:   state_d = S_ERROR;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    fetch_error = 1'b0;
    case (state_q)
      S_FETCH: imem_req    = 1'b1;
      S_ISSUE: instr_valid = 1'b1;
`ifdef FETCH_TIMEOUT_EN
      S_ERROR: fetch_error = 1'b1;
`endif
      default: ;
    endcase
  end

  always_comb begin
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    count_d    = count_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
        end
      end
      S_ISSUE:   if (instr_ready)   count_d = count_q + 32'd1;
      S_RESOLVE: if (resolve_valid) pc_d    = next_pc;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      count_q    <= count_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instr_out   = instr_q;
  assign instr_pc    = instr_pc_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed corner cases plus randomized handshakes
// checked against a transaction-level PC/count model. Define FETCH_TIMEOUT_EN to cover the timeout.
module tb_fetch_sequencer;

  localparam int TO_CYCLES = 16;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        resolve_valid;
  logic        branch_control;
  logic        alu_zero_control;
  logic        jump_control;
  logic [31:0] pc;
  logic [31:0] fetch_count;
  logic        fetch_error;

  int          n_checks = 0;
  int          n_bad    = 0;
  logic [31:0] m_pc;
  logic [31:0] m_count;

  fetch_sequencer dut (
    .clock            (clock),
    .reset            (reset),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ack         (imem_ack),
    .imem_rdata       (imem_rdata),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr_out        (instr_out),
    .instr_pc         (instr_pc),
    .resolve_valid    (resolve_valid),
    .branch_control   (branch_control),
    .alu_zero_control (alu_zero_control),
    .jump_control     (jump_control),
    .pc               (pc),
    .fetch_count      (fetch_count),
    .fetch_error      (fetch_error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference next-PC from the architectural rules, using wide integer arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] ipc, input logic [31:0] instr,
                                             input bit br, input bit zr, input bit jp);
    longint p4;
    longint off;
    p4 = (longint'(ipc) + 4) % 64'h1_0000_0000;
    if (jp) return 32'((p4 / 64'h1000_0000) * 64'h1000_0000 + (longint'(instr) % 64'h400_0000) * 4);
    if (br && zr) begin
      off = longint'(instr) % 65536;
      if (off >= 32768) off = off - 65536;
      return 32'((p4 + 4 * off + 64'h1_0000_0000) % 64'h1_0000_0000);
    end
    return 32'(p4);
  endfunction

  task automatic quiet_inputs();
    imem_ack         = 1'b0;
    imem_rdata       = '0;
    instr_ready      = 1'b0;
    resolve_valid    = 1'b0;
    branch_control   = 1'b0;
    alu_zero_control = 1'b0;
    jump_control     = 1'b0;
  endtask

  // Asserts reset at the current time, checks the async reset values, releases and steps into FETCH.
  task automatic do_reset();
    reset = 1'b1;
    quiet_inputs();
    #1;
    check("rst_pc",    pc,          32'h0);
    check("rst_addr",  imem_addr,   32'h0);
    check("rst_req",   imem_req,    32'h0);
    check("rst_valid", instr_valid, 32'h0);
    check("rst_instr", instr_out,   32'h0);
    check("rst_ipc",   instr_pc,    32'h0);
    check("rst_count", fetch_count, 32'h0);
    check("rst_err",   fetch_error, 32'h0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("idle_req", imem_req, 32'h0);
    @(negedge clock);
    m_pc    = 32'h0;
    m_count = 32'h0;
  endtask

  // One full instruction starting at the first FETCH negedge; ends at the next FETCH negedge.
  task automatic run_instr(input int ack_dly, input int rdy_dly, input int res_dly,
                           input logic [31:0] data, input bit br, input bit zr, input bit jp,
                           input bit noise);
    logic [31:0] p;
    p = m_pc;
    for (int i = 0; i <= ack_dly; i++) begin
      check("f_req",   imem_req,    32'h1);
      check("f_addr",  imem_addr,   p);
      check("f_pc",    pc,          p);
      check("f_valid", instr_valid, 32'h0);
      imem_ack   = (i == ack_dly);
      imem_rdata = (i == ack_dly) ? data : $urandom;
      if (noise) begin
        resolve_valid    = 1'($urandom);
        branch_control   = 1'($urandom);
        alu_zero_control = 1'($urandom);
        jump_control     = 1'($urandom);
        instr_ready      = 1'($urandom);
      end
      @(negedge clock);
    end
    quiet_inputs();
    for (int i = 0; i <= rdy_dly; i++) begin
      check("i_valid", instr_valid, 32'h1);
      check("i_req",   imem_req,    32'h0);
      check("i_instr", instr_out,   data);
      check("i_ipc",   instr_pc,    p);
      check("i_count", fetch_count, m_count);
      check("i_err",   fetch_error, 32'h0);
      instr_ready = (i == rdy_dly);
      if (noise) begin
        imem_ack         = 1'($urandom);
        imem_rdata       = $urandom;
        resolve_valid    = 1'($urandom);
        branch_control   = 1'($urandom);
        alu_zero_control = 1'($urandom);
        jump_control     = 1'($urandom);
      end
      @(negedge clock);
    end
    quiet_inputs();
    m_count = m_count + 32'd1;
    for (int i = 0; i <= res_dly; i++) begin
      check("r_valid", instr_valid, 32'h0);
      check("r_req",   imem_req,    32'h0);
      check("r_count", fetch_count, m_count);
      check("r_pc",    pc,          p);
      resolve_valid    = (i == res_dly);
      branch_control   = (i == res_dly) ? br : 1'($urandom);
      alu_zero_control = (i == res_dly) ? zr : 1'($urandom);
      jump_control     = (i == res_dly) ? jp : 1'($urandom);
      if (noise) begin
        imem_ack    = 1'($urandom);
        imem_rdata  = $urandom;
        instr_ready = 1'($urandom);
      end
      @(negedge clock);
    end
    quiet_inputs();
    m_pc = model_next(p, data, br, zr, jp);
  endtask

  initial begin
    reset = 1'b1;
    quiet_inputs();
    do_reset();

    // Zero-wait sequential fetches from reset.
    run_instr(0, 0, 0, $urandom, 0, 0, 0, 0);
    run_instr(0, 0, 0, $urandom, 0, 0, 0, 0);
    run_instr(0, 0, 0, $urandom, 0, 0, 0, 0);
    check("seq_pc",    pc,          32'hC);
    check("seq_count", fetch_count, 32'd3);

    // Jump to 0x40, then taken and not-taken backward branch.
    run_instr(0, 0, 0, 32'h0800_0010, 0, 0, 1, 0);
    check("jmp40_pc", pc, 32'h40);
    run_instr(0, 0, 0, 32'h1000_FFFF, 1, 1, 0, 0);
    check("br_taken_pc", pc, 32'h40);
    run_instr(0, 0, 0, 32'h1000_FFFF, 1, 0, 0, 0);
    check("br_not_taken_pc", pc, 32'h44);

    // Climb into the 0x1 region, then jump-over-branch priority.
    run_instr(0, 0, 0, 32'h0BFF_FFFF, 0, 0, 1, 0);
    check("jmp_max_pc", pc, 32'h0FFF_FFFC);
    run_instr(0, 0, 0, $urandom, 0, 0, 0, 0);
    check("region_cross_pc", pc, 32'h1000_0000);
    run_instr(0, 0, 0, 32'h1000_0003, 1, 1, 0, 0);
    check("br_fwd_pc", pc, 32'h1000_0010);
    run_instr(0, 0, 0, 32'h0800_0100, 1, 1, 1, 0);
    check("jmp_prio_pc", pc, 32'h1000_0400);

    // Slow memory and slow decode with ignored-input noise.
    run_instr(5, 3, 1, $urandom, 0, 0, 0, 1);
    check("slow_count", fetch_count, m_count);

    for (int n = 0; n < 40; n++) begin
      run_instr($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 3), $urandom,
                1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 1);
    end
    check("rand_pc",    pc,          m_pc);
    check("rand_count", fetch_count, m_count);

    // Reset while issuing.
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clock);
    imem_ack = 1'b0;
    check("pre_rst_valid", instr_valid, 32'h1);
    do_reset();
    run_instr(0, 0, 0, $urandom, 0, 0, 0, 0);
    check("post_rst_pc", pc, 32'h4);

    // Reset while an imem request is outstanding.
    check("pre_rst_req", imem_req, 32'h1);
    @(negedge clock);
    check("pre_rst_req2", imem_req, 32'h1);
    do_reset();

    // Backward branch from 0 to the top word, then sequential wrap to 0.
    run_instr(0, 0, 0, 32'h1000_FFFE, 1, 1, 0, 0);
    check("wrap_top_pc", pc, 32'hFFFF_FFFC);
    run_instr(0, 0, 0, $urandom, 0, 0, 0, 0);
    check("wrap_zero_pc", pc, 32'h0);

`ifdef FETCH_TIMEOUT_EN
    for (int i = 1; i <= TO_CYCLES; i++) begin
      check("to_req", imem_req,    32'h1);
      check("to_err", fetch_error, 32'h0);
      @(negedge clock);
    end
    check("to_err_set", fetch_error, 32'h1);
    check("to_req_off", imem_req,    32'h0);
    imem_ack = 1'b1;
    repeat (3) @(negedge clock);
    imem_ack = 1'b0;
    check("to_err_sticky", fetch_error, 32'h1);
    check("to_valid_off",  instr_valid, 32'h0);
    do_reset();
    check("to_err_clear", fetch_error, 32'h0);
    run_instr(TO_CYCLES - 1, 0, 0, $urandom, 0, 0, 0, 0);
    check("to_last_ack_err", fetch_error, 32'h0);
`else
    for (int i = 0; i < 40; i++) begin
      check("wait_req",  imem_req,    32'h1);
      check("wait_addr", imem_addr,   m_pc);
      check("wait_err",  fetch_error, 32'h0);
      @(negedge clock);
    end
    run_instr(0, 0, 0, $urandom, 0, 0, 0, 0);
`endif
    check("final_pc",    pc,          m_pc);
    check("final_count", fetch_count, m_count);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
